// File: rtl/rob_commit_queue_pkg.sv
// rob_commit_queue_pkg
//   Shared defaults for the reorder-buffer commit queue, the flat layout of one
//   queue entry, and the per-cycle operation selector used by the top.
//   No ports (package).
package rob_commit_queue_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_IDX_W  = $clog2(ROB_DEPTH);
  localparam int WB_PORTS   = 2;
  localparam int ROB_DATA_W = 32;

  // Entry layout, LSB first: {addr, val, done, busy}
  localparam int ENT_BUSY_OFS = 0;
  localparam int ENT_DONE_OFS = 1;
  localparam int ENT_VAL_OFS  = 2;

  function automatic int ent_addr_ofs(input int data_w);
    return ENT_VAL_OFS + data_w;
  endfunction

  function automatic int ent_w(input int data_w);
    return ENT_VAL_OFS + 2 * data_w;
  endfunction

  // What the queue does on the coming edge (reset is handled separately).
  typedef enum logic [1:0] {
    Q_HOLD   = 2'd0,
    Q_FLUSH  = 2'd1,
    Q_UPDATE = 2'd2
  } q_op_e;

endpackage

// File: rtl/rob_commit_queue_if.sv
// rob_commit_queue_if
//   Allocation, writeback and commit handshakes of the commit queue.
//   master : producer/consumer side (drives alloc_valid/addr, wb_*, commit_ready)
//   slave  : the queue (drives alloc_ready/tag, commit_valid/tag/val/addr)
//   Writeback ports are packed; port k lives at bits [k*W +: W].
interface rob_commit_queue_if
  import rob_commit_queue_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int N_WB   = WB_PORTS,
  parameter int DATA_W = ROB_DATA_W,
  parameter int IDX_W  = $clog2(DEPTH)
);

  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [DATA_W-1:0]      alloc_addr;
  logic [IDX_W-1:0]       alloc_tag;

  logic [N_WB-1:0]        wb_valid;
  logic [N_WB*IDX_W-1:0]  wb_tag;
  logic [N_WB*DATA_W-1:0] wb_val;

  logic                   commit_valid;
  logic                   commit_ready;
  logic [IDX_W-1:0]       commit_tag;
  logic [DATA_W-1:0]      commit_val;
  logic [DATA_W-1:0]      commit_addr;

  modport master (
    output alloc_valid, alloc_addr, wb_valid, wb_tag, wb_val, commit_ready,
    input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_val, commit_addr
  );

  modport slave (
    input  alloc_valid, alloc_addr, wb_valid, wb_tag, wb_val, commit_ready,
    output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_val, commit_addr
  );

endinterface

// File: rtl/rob_commit_queue_wb_select.sv
// rob_wb_select
//   Combinational per-entry writeback select. For every entry, finds the
//   lowest-index writeback port addressing it and raises a write enable only
//   when the entry is busy and not yet done.
//   busy_i, done_i : per-entry status
//   wb_valid_i/wb_tag_i/wb_val_i : packed writeback ports
//   wr_en_o, wr_val_o : per-entry write enable and value
module rob_wb_select #(
  parameter int DEPTH  = 8,
  parameter int N_WB   = 2,
  parameter int DATA_W = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]              busy_i,
  input  logic [DEPTH-1:0]              done_i,
  input  logic [N_WB-1:0]               wb_valid_i,
  input  logic [N_WB*IDX_W-1:0]         wb_tag_i,
  input  logic [N_WB*DATA_W-1:0]        wb_val_i,
  output logic [DEPTH-1:0]              wr_en_o,
  output logic [DEPTH-1:0][DATA_W-1:0]  wr_val_o
);

  always_comb begin
    wr_en_o  = '0;
    wr_val_o = '0;
    for (int e = 0; e < DEPTH; e++) begin
      // Scan from the highest port down so the lowest matching port is the
      // last assignment and therefore wins.
      for (int k = N_WB - 1; k >= 0; k--) begin
        if (wb_valid_i[k] && (wb_tag_i[k*IDX_W +: IDX_W] == IDX_W'(e))) begin
          wr_en_o[e]  = busy_i[e] && !done_i[e];
          wr_val_o[e] = wb_val_i[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/rob_commit_queue.sv
// rob_commit_queue
//   In-order commit queue: entries are allocated at tail, completed out of
//   order by writeback ports, and retired from head strictly in order.
//   clk_in   : clock, all state on rising edge
//   rst_n_in : synchronous active-low reset, beats rdy_in and flush
//   rdy_in   : global enable; low freezes state and masks handshakes
//   flush    : clears every entry and both pointers
//   rob_if   : alloc / writeback / commit handshakes (slave side)
//   count, full, empty : registered occupancy
module rob_commit_queue
  import rob_commit_queue_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int N_WB   = WB_PORTS,
  parameter int DATA_W = ROB_DATA_W,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush,
  rob_commit_queue_if.slave rob_if,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int              ENT_W     = ent_w(DATA_W);
  localparam int              ADDR_OFS  = ent_addr_ofs(DATA_W);
  localparam logic [IDX_W:0]  DEPTH_CNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0][ENT_W-1:0]  ent_q, ent_d;
  logic [IDX_W-1:0]             head_q, head_d;
  logic [IDX_W-1:0]             tail_q, tail_d;
  logic [IDX_W:0]               count_q, count_d;
  logic                         full_q, full_d;
  logic                         empty_q, empty_d;

  logic [DEPTH-1:0]             busy_vec;
  logic [DEPTH-1:0]             done_vec;
  logic [DEPTH-1:0]             wr_en;
  logic [DEPTH-1:0][DATA_W-1:0] wr_val;
  logic [ENT_W-1:0]             head_ent;
  logic                         alloc_fire;
  logic                         commit_fire;
  q_op_e                        op;

  always_comb begin
    busy_vec = '0;
    done_vec = '0;
    for (int e = 0; e < DEPTH; e++) begin
      busy_vec[e] = ent_q[e][ENT_BUSY_OFS];
      done_vec[e] = ent_q[e][ENT_DONE_OFS];
    end
  end

  rob_wb_select #(
    .DEPTH  (DEPTH),
    .N_WB   (N_WB),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_wb_select (
    .busy_i     (busy_vec),
    .done_i     (done_vec),
    .wb_valid_i (rob_if.wb_valid),
    .wb_tag_i   (rob_if.wb_tag),
    .wb_val_i   (rob_if.wb_val),
    .wr_en_o    (wr_en),
    .wr_val_o   (wr_val)
  );

  assign head_ent = ent_q[head_q];

  // Handshakes look only at registered state: full blocks allocation even if
  // a commit frees a slot this cycle, and a writeback cannot commit until the
  // cycle after it lands.
  assign rob_if.alloc_ready  = rdy_in && !full_q;
  assign rob_if.alloc_tag    = tail_q;
  assign rob_if.commit_valid = rdy_in && head_ent[ENT_BUSY_OFS] && head_ent[ENT_DONE_OFS];
  assign rob_if.commit_tag   = head_q;
  assign rob_if.commit_val   = head_ent[ENT_VAL_OFS +: DATA_W];
  assign rob_if.commit_addr  = head_ent[ADDR_OFS +: DATA_W];

  assign alloc_fire  = rob_if.alloc_valid && rob_if.alloc_ready;
  assign commit_fire = rob_if.commit_valid && rob_if.commit_ready;

  always_comb begin
    if (!rdy_in)     op = Q_HOLD;
    else if (flush)  op = Q_FLUSH;
    else             op = Q_UPDATE;
  end

  // Writeback, commit and alloc never touch the same entry in one cycle:
  // writeback needs busy&&!done, commit needs done, and alloc needs a free
  // tail slot, which cannot coincide with head while entries are live.
  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case (op)
      Q_FLUSH: begin
        ent_d   = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      Q_UPDATE: begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wr_en[e]) begin
            ent_d[e][ENT_DONE_OFS]            = 1'b1;
            ent_d[e][ENT_VAL_OFS +: DATA_W]   = wr_val[e];
          end
        end
        if (commit_fire) begin
          ent_d[head_q][ENT_BUSY_OFS] = 1'b0;
          ent_d[head_q][ENT_DONE_OFS] = 1'b0;
          head_d = head_q + 1'b1;
        end
        if (alloc_fire) begin
          ent_d[tail_q]                         = '0;
          ent_d[tail_q][ENT_BUSY_OFS]           = 1'b1;
          ent_d[tail_q][ADDR_OFS +: DATA_W]     = rob_if.alloc_addr;
          tail_d = tail_q + 1'b1;
        end
        unique case ({alloc_fire, commit_fire})
          2'b10:   count_d = count_q + 1'b1;
          2'b01:   count_d = count_q - 1'b1;
          default: count_d = count_q;
        endcase
      end
      default: begin
      end
    endcase
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_rob_commit_queue.sv
// tb_rob_commit_queue
//   Directed bench for rob_commit_queue with DEPTH=8, N_WB=2, DATA_W=32.
module tb_rob_commit_queue;
  import rob_commit_queue_pkg::*;

  localparam int DEPTH  = ROB_DEPTH;
  localparam int N_WB   = WB_PORTS;
  localparam int DATA_W = ROB_DATA_W;
  localparam int IDX_W  = ROB_IDX_W;

  logic           clk_in;
  logic           rst_n_in;
  logic           rdy_in;
  logic           flush;
  logic [IDX_W:0] count;
  logic           full;
  logic           empty;

  int checks = 0;
  int errors = 0;

  rob_commit_queue_if #(
    .DEPTH(DEPTH), .N_WB(N_WB), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) bus ();

  rob_commit_queue #(
    .DEPTH(DEPTH), .N_WB(N_WB), .DATA_W(DATA_W), .IDX_W(IDX_W)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .rdy_in   (rdy_in),
    .flush    (flush),
    .rob_if   (bus),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [1:0] v, input logic [2:0] t0, input logic [2:0] t1,
                    input logic [31:0] v0, input logic [31:0] v1);
    bus.wb_valid = v;
    bus.wb_tag   = {t1, t0};
    bus.wb_val   = {v1, v0};
  endtask

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    flush    = 1'b0;
    bus.alloc_valid  = 1'b0;
    bus.alloc_addr   = '0;
    bus.commit_ready = 1'b0;
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    tick();
    tick();
    rst_n_in = 1'b1;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_commit_valid", bus.commit_valid, 0);
    chk("rst_alloc_tag", bus.alloc_tag, 0);
    chk("rst_alloc_ready", bus.alloc_ready, 1);

    // Fill all eight slots
    for (int i = 0; i < 8; i++) begin
      bus.alloc_valid = 1'b1;
      bus.alloc_addr  = 32'(32'h100 + 4 * i);
      #1;
      chk("fill_tag", bus.alloc_tag, 64'(i));
      chk("fill_ready", bus.alloc_ready, 1);
      tick();
    end
    #1;
    chk("full_flag", full, 1);
    chk("full_count", count, 8);
    chk("full_alloc_ready", bus.alloc_ready, 0);
    chk("full_empty", empty, 0);
    tick();
    chk("full_count_hold", count, 8);
    chk("full_tag_hold", bus.alloc_tag, 0);
    bus.alloc_valid = 1'b0;

    // Out-of-order writeback, in-order commit
    wb(2'b01, 3'd2, 3'd0, 32'hA, 32'h0);
    tick();
    wb(2'b01, 3'd1, 3'd0, 32'hB, 32'h0);
    #1;
    chk("ooo_no_commit_a", bus.commit_valid, 0);
    tick();
    wb(2'b01, 3'd0, 3'd0, 32'hC, 32'h0);
    #1;
    chk("ooo_no_bypass", bus.commit_valid, 0);
    tick();
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    #1;
    chk("ooo_cv0", bus.commit_valid, 1);
    chk("ooo_tag0", bus.commit_tag, 0);
    chk("ooo_val0", bus.commit_val, 32'hC);
    chk("ooo_addr0", bus.commit_addr, 32'h100);
    bus.commit_ready = 1'b1;
    tick();
    chk("ooo_tag1", bus.commit_tag, 1);
    chk("ooo_val1", bus.commit_val, 32'hB);
    chk("ooo_addr1", bus.commit_addr, 32'h104);
    tick();
    chk("ooo_tag2", bus.commit_tag, 2);
    chk("ooo_val2", bus.commit_val, 32'hA);
    chk("ooo_addr2", bus.commit_addr, 32'h108);
    tick();
    chk("ooo_cv_after", bus.commit_valid, 0);
    chk("ooo_count", count, 5);

    // Two ports hit tag 3 in one cycle; port 0 wins
    wb(2'b11, 3'd3, 3'd3, 32'h11, 32'h22);
    tick();
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    bus.commit_ready = 1'b0;
    #1;
    chk("conf_cv", bus.commit_valid, 1);
    chk("conf_tag", bus.commit_tag, 3);
    chk("conf_val", bus.commit_val, 32'h11);
    wb(2'b10, 3'd0, 3'd3, 32'h0, 32'h33);
    tick();
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    #1;
    chk("conf_late_wb_ignored", bus.commit_val, 32'h11);
    bus.commit_ready = 1'b1;
    tick();
    chk("conf_count", count, 4);
    chk("conf_cv_after", bus.commit_valid, 0);
    bus.commit_ready = 1'b0;

    // Wrap: complete 4..7, alloc+commit together, then refill tags 2..5
    wb(2'b11, 3'd4, 3'd5, 32'h44, 32'h55);
    tick();
    wb(2'b11, 3'd6, 3'd7, 32'h66, 32'h77);
    tick();
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    bus.alloc_valid  = 1'b1;
    bus.alloc_addr   = 32'h200;
    bus.commit_ready = 1'b1;
    #1;
    chk("wrap_ctag4", bus.commit_tag, 4);
    chk("wrap_cval4", bus.commit_val, 32'h44);
    chk("wrap_atag0", bus.alloc_tag, 0);
    tick();
    bus.alloc_addr = 32'h204;
    #1;
    chk("wrap_count_same", count, 4);
    chk("wrap_ctag5", bus.commit_tag, 5);
    chk("wrap_cval5", bus.commit_val, 32'h55);
    chk("wrap_atag1", bus.alloc_tag, 1);
    tick();
    bus.commit_ready = 1'b0;
    for (int i = 2; i < 6; i++) begin
      bus.alloc_addr = 32'(32'h200 + 4 * i);
      #1;
      chk("wrap_atag", bus.alloc_tag, 64'(i));
      tick();
    end
    chk("wrap_count8", count, 8);
    chk("wrap_full", full, 1);
    bus.alloc_addr   = 32'h300;
    bus.commit_ready = 1'b1;
    #1;
    chk("full_no_bypass", bus.alloc_ready, 0);
    chk("wrap_cv6", bus.commit_valid, 1);
    chk("wrap_ctag6", bus.commit_tag, 6);
    chk("wrap_cval6", bus.commit_val, 32'h66);
    chk("wrap_caddr6", bus.commit_addr, 32'h118);
    tick();
    bus.alloc_valid = 1'b0;
    #1;
    chk("wrap_count7", count, 7);
    chk("wrap_ctag7", bus.commit_tag, 7);
    chk("wrap_cval7", bus.commit_val, 32'h77);
    chk("wrap_caddr7", bus.commit_addr, 32'h11C);
    chk("wrap_atag6", bus.alloc_tag, 6);
    tick();
    bus.commit_ready = 1'b0;
    #1;
    chk("wrap_count6", count, 6);
    chk("wrap_cv_head0", bus.commit_valid, 0);
    chk("wrap_notfull", full, 0);
    wb(2'b01, 3'd0, 3'd0, 32'h90, 32'h0);
    tick();
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    #1;
    chk("wrap_cv0", bus.commit_valid, 1);
    chk("wrap_ctag0", bus.commit_tag, 0);
    chk("wrap_cval0", bus.commit_val, 32'h90);
    chk("wrap_caddr0", bus.commit_addr, 32'h200);

    // Pause: everything asserted while rdy_in is low must be ignored
    rdy_in           = 1'b0;
    bus.alloc_valid  = 1'b1;
    bus.alloc_addr   = 32'h400;
    bus.commit_ready = 1'b1;
    flush            = 1'b1;
    wb(2'b01, 3'd1, 3'd0, 32'h5A, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("pause_alloc_ready", bus.alloc_ready, 0);
      chk("pause_commit_valid", bus.commit_valid, 0);
      tick();
      chk("pause_count", count, 6);
    end
    rdy_in           = 1'b1;
    bus.alloc_valid  = 1'b0;
    bus.commit_ready = 1'b0;
    flush            = 1'b0;
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    #1;
    chk("resume_cv", bus.commit_valid, 1);
    chk("resume_cval", bus.commit_val, 32'h90);
    chk("resume_caddr", bus.commit_addr, 32'h200);
    chk("resume_atag", bus.alloc_tag, 6);
    chk("resume_count", count, 6);
    chk("resume_alloc_ready", bus.alloc_ready, 1);
    bus.commit_ready = 1'b1;
    tick();
    bus.commit_ready = 1'b0;
    #1;
    chk("resume_count5", count, 5);
    chk("resume_wb_dropped", bus.commit_valid, 0);
    chk("resume_ctag1", bus.commit_tag, 1);

    // Flush beats a same-cycle alloc and writeback
    flush           = 1'b1;
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 32'h500;
    wb(2'b01, 3'd1, 3'd0, 32'h77, 32'h0);
    tick();
    flush           = 1'b0;
    bus.alloc_valid = 1'b0;
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    #1;
    chk("flush_empty", empty, 1);
    chk("flush_count", count, 0);
    chk("flush_cv", bus.commit_valid, 0);
    chk("flush_atag", bus.alloc_tag, 0);
    chk("flush_full", full, 0);

    // Reset mid-operation discards completed entries, even with rdy_in low
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 32'h600;
    tick();
    bus.alloc_addr  = 32'h604;
    tick();
    bus.alloc_valid = 1'b0;
    wb(2'b11, 3'd0, 3'd1, 32'hA0, 32'hA1);
    tick();
    wb(2'b00, 3'd0, 3'd0, 32'h0, 32'h0);
    #1;
    chk("pre_rst_cv", bus.commit_valid, 1);
    chk("pre_rst_cval", bus.commit_val, 32'hA0);
    chk("pre_rst_count", count, 2);
    rst_n_in = 1'b0;
    rdy_in   = 1'b0;
    tick();
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_alloc_ready", bus.alloc_ready, 0);
    rst_n_in = 1'b1;
    rdy_in   = 1'b1;
    bus.commit_ready = 1'b1;
    #1;
    chk("post_rst_cv", bus.commit_valid, 0);
    chk("post_rst_atag", bus.alloc_tag, 0);
    chk("post_rst_alloc_ready", bus.alloc_ready, 1);
    tick();
    chk("post_rst_cv_hold", bus.commit_valid, 0);
    chk("post_rst_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rob_commit_queue.md
ROB_COMMIT_QUEUE -- requirements
Module: rob_commit_queue

Interface
REQ-001 SHALL have parameters: DEPTH, default 8, entry count (power of 2, >=2); N_WB, default 2, writeback port count; DATA_W, default 32, value/address width; IDX_W = log2(DEPTH), derived.
REQ-002 SHALL have ports: clk_in  in  1  single clock, all state on rising edge.
REQ-003 rst_n_in  in  1  reset, synchronous, active-low.
REQ-004 rdy_in  in  1  global enable; low = pause.
REQ-005 alloc_valid  in  1  / alloc_ready  out  1  / alloc_addr  in  DATA_W  / alloc_tag  out  IDX_W: allocation handshake, source PC, slot index granted.
REQ-006 wb_valid  in  N_WB  / wb_tag  in  N_WB*IDX_W  / wb_val  in  N_WB*DATA_W: packed writeback ports, port k at bits [k*W +: W].
REQ-007 commit_valid  out  1  / commit_ready  in  1  / commit_tag  out  IDX_W  / commit_val, commit_addr  out  DATA_W: in-order retire handshake.
REQ-008 flush  in  1  misprediction clear; count  out  IDX_W+1; full, empty  out  1.

Function
REQ-009 Each entry SHALL hold {busy, done, val, addr}; head and tail pointers IDX_W bits, wrap DEPTH-1 -> 0 naturally.
REQ-010 alloc_ready SHALL equal rdy_in && !full; alloc_tag SHALL equal tail combinationally.
REQ-011 Allocation fires when alloc_valid && alloc_ready: entry[tail] <= {busy=1, done=0, val=0, addr=alloc_addr}, tail+1, visible next cycle.
REQ-012 Writeback port k SHALL set done=1 and val=wb_val[k] on entry[wb_tag[k]] only if busy && !done; otherwise ignored (no error).
REQ-013 Multiple ports targeting one tag in one cycle: lowest-index port wins; others dropped.
REQ-014 commit_valid SHALL equal rdy_in && busy[head] && done[head]; commit_tag/val/addr from entry[head], combinational from registers.
REQ-015 Commit fires when commit_valid && commit_ready: busy[head], done[head] cleared, head+1; entries strictly in allocation order.
REQ-016 Latency: writeback at edge t -> commit_valid high cycle after t; no same-cycle bypass from wb to commit.
REQ-017 Allocation and commit in same cycle SHALL both occur; count unchanged.
REQ-018 count = occupied entries; full = (count == DEPTH); empty = (count == 0); registered.
REQ-019 When full, alloc_ready SHALL be 0 even if commit fires that cycle (no bypass).
REQ-020 flush SHALL have priority over alloc, wb, commit that cycle: all busy/done cleared, head=tail=count=0.
REQ-021 rdy_in low SHALL freeze all state, ignore alloc/wb/commit/flush; alloc_ready and commit_valid forced 0.
REQ-022 Non-head done entries SHALL never commit before head.

Reset
REQ-023 rst_n_in low at clock edge SHALL clear all entries, head=tail=0, count=0; takes priority over rdy_in and flush.
REQ-024 After reset: empty=1, full=0, commit_valid=0, alloc_tag=0, alloc_ready=rdy_in.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight entries; no commit issued for them.

Structure
REQ-026 ROB_DEPTH, ROB_IDX_W, WB_PORTS defaults SHALL live in shared macros.v; entry field offsets defined there.
REQ-027 One sub-module rob_wb_select SHALL perform per-entry writeback port priority select (combinational); rest in rob_commit_queue.
REQ-028 RTL SHALL avoid loop-carried blocking assignments to state registers.

Verification
REQ-029 Fill: 8 allocs addr 0x100..0x11C -> tags 0..7, full=1, alloc_ready=0 on 9th.
REQ-030 Out-of-order wb: tags 2,1,0 vals 0xA,0xB,0xC on port 0 over 3 cycles -> commits tag0 0xC, tag1 0xB, tag2 0xA in order, commit_ready=1.
REQ-031 Conflict: port0 and port1 both tag 3 vals 0x11/0x22 -> commit_val 0x11; later wb to tag 3 ignored.
REQ-032 Wrap: commit 6, alloc 6 more -> tags 0..5 reused after 6,7, count=8, order preserved.
REQ-033 Flush with alloc and wb same cycle -> next cycle empty=1, count=0, commit_valid=0, alloc_tag=0.
REQ-034 rdy_in low 3 cycles with alloc_valid, wb_valid, commit_ready high -> state, count unchanged; resumes identically after.
